// File: rtl/fetch_hazard_stage.sv
// Instruction fetch with IF/ID register, load-use stall and branch redirect/flush.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush event counters.
module fetch_hazard_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        PCSrc,
    input  logic [31:0] branch_target,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_Register_Rt,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc4,
    output logic        IF_ID_valid,
    output logic        stall,
    output logic        flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        hazard;

    assign pc_next   = pc_reg + PC_STEP;
    assign imem_addr = pc_reg;

    // Flushed IF/ID has valid=0, so a nop never creates a hazard.
    assign hazard = ID_EX_MemRead && IF_ID_valid && (ID_EX_Register_Rt != 5'd0) &&
                    ((ID_EX_Register_Rt == IF_ID_instr[25:21]) ||
                     (ID_EX_Register_Rt == IF_ID_instr[20:16]));

    assign stall = hazard && !PCSrc;
    assign flush = PCSrc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg      <= RESET_PC;
            IF_ID_instr <= 32'd0;
            IF_ID_pc4   <= 32'd0;
            IF_ID_valid <= 1'b0;
        end else if (PCSrc) begin
            pc_reg      <= branch_target;
            IF_ID_instr <= 32'd0;
            IF_ID_pc4   <= 32'd0;
            IF_ID_valid <= 1'b0;
        end else if (!stall) begin
            pc_reg      <= pc_next;
            IF_ID_instr <= imem_data;
            IF_ID_pc4   <= pc_next;
            IF_ID_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (stall && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
            if (PCSrc && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_hazard_stage.sv
// Directed bench for fetch_hazard_stage: fetch, load-use stall, redirect, async reset, PC wrap.
// FETCH_PERF_CNT_EN, when defined, also exercises the event counters.
module tb_fetch_hazard_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_Register_Rt;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc4;
    logic        IF_ID_valid;
    logic        stall;
    logic        flush;

    logic        use_addr;
    logic [31:0] imem_word;

    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic        w_valid;
    logic        w_stall;
    logic        w_flush;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] ADD_RS2 = 32'h0044_1820;  // add $3,$2,$4
    localparam logic [31:0] ADD_RS0 = 32'h0000_1820;  // add $3,$0,$0

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
    logic [31:0] w_stall_count;
    logic [31:0] w_flush_count;
`endif

    fetch_hazard_stage u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .PCSrc             (PCSrc),
        .branch_target     (branch_target),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_Register_Rt (ID_EX_Register_Rt),
        .IF_ID_instr       (IF_ID_instr),
        .IF_ID_pc4         (IF_ID_pc4),
        .IF_ID_valid       (IF_ID_valid),
        .stall             (stall),
        .flush             (flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_count       (stall_count),
        .flush_count       (flush_count)
`endif
    );

    fetch_hazard_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_addr         (w_addr),
        .imem_data         (32'd0),
        .PCSrc             (1'b0),
        .branch_target     (32'd0),
        .ID_EX_MemRead     (1'b0),
        .ID_EX_Register_Rt (5'd0),
        .IF_ID_instr       (w_instr),
        .IF_ID_pc4         (w_pc4),
        .IF_ID_valid       (w_valid),
        .stall             (w_stall),
        .flush             (w_flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_count       (w_stall_count),
        .flush_count       (w_flush_count)
`endif
    );

    always_comb begin
        imem_data = imem_word;
        if (use_addr) imem_data = imem_addr;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n             = 1'b0;
        PCSrc             = 1'b0;
        branch_target     = 32'd0;
        ID_EX_MemRead     = 1'b0;
        ID_EX_Register_Rt = 5'd0;
        use_addr          = 1'b1;
        imem_word         = 32'd0;

        #3;
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_instr", IF_ID_instr, 32'h0);
        check("rst_pc4",   IF_ID_pc4, 32'h0);
        check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        #9 rst_n = 1'b1;

        // free run, data = address
        tick();
        check("run1_addr",  imem_addr, 32'd4);
        check("run1_instr", IF_ID_instr, 32'd0);
        check("run1_pc4",   IF_ID_pc4, 32'd4);
        check("run1_valid", {31'd0, IF_ID_valid}, 32'd1);
        tick();
        check("run2_addr",  imem_addr, 32'd8);
        check("run2_instr", IF_ID_instr, 32'd4);
        tick();
        check("run3_addr",  imem_addr, 32'd12);
        check("run3_instr", IF_ID_instr, 32'd8);

        // load-use on rs
        use_addr  = 1'b0;
        imem_word = ADD_RS2;
        tick();
        check("hz_addr",  imem_addr, 32'd16);
        check("hz_instr", IF_ID_instr, ADD_RS2);
        ID_EX_MemRead     = 1'b1;
        ID_EX_Register_Rt = 5'd2;
        #1;
        check("hz_stall", {31'd0, stall}, 32'd1);
        check("hz_flush", {31'd0, flush}, 32'd0);
        imem_word = 32'hDEAD_BEEF;
        tick();
        check("hz_hold_addr",  imem_addr, 32'd16);
        check("hz_hold_instr", IF_ID_instr, ADD_RS2);
        check("hz_hold_pc4",   IF_ID_pc4, 32'd16);
        ID_EX_MemRead = 1'b0;
        #1;
        check("hz_release", {31'd0, stall}, 32'd0);
        imem_word = ADD_RS0;
        tick();
        check("hz_resume_addr", imem_addr, 32'd20);
        check("hz_resume_instr", IF_ID_instr, ADD_RS0);

        // load into $0 matching rs=0 never stalls
        ID_EX_MemRead     = 1'b1;
        ID_EX_Register_Rt = 5'd0;
        imem_word         = ADD_RS2;
        #1;
        check("r0_stall", {31'd0, stall}, 32'd0);
        tick();
        check("r0_addr", imem_addr, 32'd24);

        // rt field match and non-match
        ID_EX_Register_Rt = 5'd4;
        #1;
        check("rt_stall", {31'd0, stall}, 32'd1);
        ID_EX_Register_Rt = 5'd5;
        #1;
        check("nomatch_stall", {31'd0, stall}, 32'd0);
        ID_EX_MemRead     = 1'b0;
        ID_EX_Register_Rt = 5'd4;
        #1;
        check("noload_stall", {31'd0, stall}, 32'd0);

        // redirect wins over hazard
        ID_EX_MemRead     = 1'b1;
        ID_EX_Register_Rt = 5'd2;
        PCSrc             = 1'b1;
        branch_target     = 32'h40;
        #1;
        check("br_stall", {31'd0, stall}, 32'd0);
        check("br_flush", {31'd0, flush}, 32'd1);
        tick();
        check("br_addr",  imem_addr, 32'h40);
        check("br_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("br_instr", IF_ID_instr, 32'd0);
        check("br_pc4",   IF_ID_pc4, 32'd0);
        PCSrc         = 1'b0;
        ID_EX_MemRead = 1'b0;
        use_addr      = 1'b1;
        tick();
        check("br_tgt_addr",  imem_addr, 32'h44);
        check("br_tgt_pc4",   IF_ID_pc4, 32'h44);
        check("br_tgt_instr", IF_ID_instr, 32'h40);
        check("br_tgt_valid", {31'd0, IF_ID_valid}, 32'd1);

        // PCSrc held for two cycles
        PCSrc         = 1'b1;
        branch_target = 32'h100;
        tick();
        check("br2a_addr",  imem_addr, 32'h100);
        check("br2a_valid", {31'd0, IF_ID_valid}, 32'd0);
        tick();
        check("br2b_addr",  imem_addr, 32'h100);
        check("br2b_valid", {31'd0, IF_ID_valid}, 32'd0);
        PCSrc = 1'b0;
        tick();
        check("br2c_addr",  imem_addr, 32'h104);
        check("br2c_instr", IF_ID_instr, 32'h100);

        // asynchronous reset during a stall
        use_addr  = 1'b0;
        imem_word = ADD_RS2;
        tick();
        ID_EX_MemRead     = 1'b1;
        ID_EX_Register_Rt = 5'd2;
        #1;
        check("ar_pre_stall", {31'd0, stall}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_addr",  imem_addr, 32'h0);
        check("ar_instr", IF_ID_instr, 32'h0);
        check("ar_pc4",   IF_ID_pc4, 32'h0);
        check("ar_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("ar_stall", {31'd0, stall}, 32'd0);
        ID_EX_MemRead = 1'b0;
        use_addr      = 1'b1;
        #1 rst_n = 1'b1;

        // wrap instance
        check("wr0_addr", w_addr, 32'hFFFF_FFF8);
        tick();
        check("wr1_addr", w_addr, 32'hFFFF_FFFC);
        tick();
        check("wr2_addr", w_addr, 32'h0000_0000);
        check("wr2_pc4",  w_pc4, 32'h0000_0000);

`ifdef FETCH_PERF_CNT_EN
        #1 rst_n = 1'b0;
        #1;
        check("cnt_rst_stall", stall_count, 32'd0);
        check("cnt_rst_flush", flush_count, 32'd0);
        rst_n     = 1'b1;
        use_addr  = 1'b0;
        imem_word = ADD_RS2;
        tick();
        ID_EX_MemRead     = 1'b1;
        ID_EX_Register_Rt = 5'd2;
        tick();
        tick();
        tick();
        ID_EX_MemRead = 1'b0;
        PCSrc         = 1'b1;
        branch_target = 32'h200;
        tick();
        tick();
        PCSrc = 1'b0;
        tick();
        check("cnt_stall", stall_count, 32'd3);
        check("cnt_flush", flush_count, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
